// File: rtl/user_switch_pkg.sv
// Shared constants for the user project switcher: FSM encoding, config address,
// pad safe states and config read-data layout.
package user_switch_pkg;

  localparam logic [1:0] StActive    = 2'd0;
  localparam logic [1:0] StSwitchOut = 2'd1;
  localparam logic [1:0] StPrst      = 2'd2;

  localparam logic [31:0] CfgAddressDefault = 32'h300F_FFFC;

  localparam logic OebSafe = 1'b1;
  localparam logic OutSafe = 1'b0;

  localparam int unsigned BusyBit = 31;

endpackage

// File: rtl/user_proj_mux.sv
// Generic N:1 indexed mux over a flattened bus; out-of-range selects yield zero.
module user_proj_mux #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N        = 4,
  parameter int unsigned SEL_BITS = 2
) (
  input  logic [WIDTH*N-1:0]  data_i,
  input  logic [SEL_BITS-1:0] sel_i,
  output logic [WIDTH-1:0]    data_o
);

  always_comb begin
    data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (sel_i == SEL_BITS'(i)) data_o = data_i[i*WIDTH +: WIDTH];
    end
  end

endmodule

// File: rtl/user_project_switcher.sv
// Multiplexes several user projects onto the Caravel WB/LA/GPIO/IRQ interfaces with a
// runtime-selectable active project and a sequenced reset/clock handover.
module user_project_switcher
  import user_switch_pkg::*;
#(
  parameter int unsigned USER_PROJECTS = 4,
  parameter int unsigned CFG_BITS      = $clog2(USER_PROJECTS),
  parameter logic [31:0] CFG_ADDRESS   = CfgAddressDefault,
  parameter int unsigned IO_PADS       = 38,
  parameter int unsigned LA_BITS       = 32,
  parameter int unsigned RST_CYCLES    = 4
) (
  input  logic                                   wb_clk_i,
  input  logic                                   wb_rst_n_i,
  input  logic                                   wbs_stb_i,
  input  logic                                   wbs_cyc_i,
  input  logic                                   wbs_we_i,
  input  logic [3:0]                             wbs_sel_i,
  input  logic [31:0]                            wbs_adr_i,
  input  logic [31:0]                            wbs_dat_i,
  output logic                                   wbs_ack_o,
  output logic [31:0]                            wbs_dat_o,
  input  logic [CFG_BITS-1:0]                    strap_cfg_i,
  output logic [USER_PROJECTS-1:0]               proj_wbs_stb_o,
  output logic [USER_PROJECTS-1:0]               proj_wbs_cyc_o,
  input  logic [USER_PROJECTS-1:0]               proj_wbs_ack_i,
  input  logic [32*USER_PROJECTS-1:0]            proj_wbs_dat_i,
  input  logic [LA_BITS*USER_PROJECTS-1:0]       proj_la_i,
  output logic [127:0]                           la_data_out,
  input  logic [(IO_PADS-CFG_BITS)*USER_PROJECTS-1:0] proj_io_out_i,
  input  logic [(IO_PADS-CFG_BITS)*USER_PROJECTS-1:0] proj_io_oeb_i,
  output logic [IO_PADS-1:0]                     io_out,
  output logic [IO_PADS-1:0]                     io_oeb,
  input  logic [3*USER_PROJECTS-1:0]             proj_irq_i,
  output logic [2:0]                             user_irq,
  output logic [USER_PROJECTS-1:0]               proj_clk_en_o,
  output logic [USER_PROJECTS-1:0]               proj_rst_n_o,
  output logic [CFG_BITS-1:0]                    active_sel_o,
  output logic                                   switch_busy_o
);

  localparam int unsigned PadW = IO_PADS - CFG_BITS;
  localparam int unsigned CntW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(RST_CYCLES - 1);

  logic [1:0]               state_q, state_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic [CFG_BITS-1:0]      active_sel_q, active_sel_d, pending_sel_q, pending_sel_d;
  logic                     cfg_ack_q;
  logic [USER_PROJECTS-1:0] clk_en_q, clk_en_d, rst_n_q, rst_n_d, sel_oh_q, sel_oh_d;
  logic [IO_PADS-1:0]       io_out_q, io_out_d, io_oeb_q, io_oeb_d;
  logic [127:0]             la_q, la_d;
  logic [2:0]               irq_q, irq_d;

  logic              is_active, cfg_hit, cfg_req, cfg_wr_ok, strap_ok, fwd, fwd_ack;
  logic [31:0]       dat_sel, cfg_rd;
  logic [LA_BITS-1:0] la_sel;
  logic [PadW-1:0]   out_sel, oeb_sel;
  logic [2:0]        irq_sel;
  logic              unused_sel;

  assign unused_sel = ^wbs_sel_i[3:1];
  assign is_active  = (state_q == StActive);
  assign strap_ok   = 32'(strap_cfg_i) < USER_PROJECTS;
  assign cfg_hit    = (wbs_adr_i == CFG_ADDRESS);
  // A request is consumed only while no ack is pending, so held strobes ack every other cycle
  assign cfg_req    = wbs_stb_i & wbs_cyc_i & cfg_hit & ~cfg_ack_q;
  assign cfg_wr_ok  = cfg_req & wbs_we_i & wbs_sel_i[0] & is_active &
                      (wbs_dat_i < USER_PROJECTS) &
                      (wbs_dat_i[CFG_BITS-1:0] != active_sel_q);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    active_sel_d  = active_sel_q;
    pending_sel_d = pending_sel_q;
    unique case (state_q)
      StActive: begin
        if (cfg_wr_ok) begin
          pending_sel_d = wbs_dat_i[CFG_BITS-1:0];
          state_d       = StSwitchOut;
        end
      end
      StSwitchOut: begin
        active_sel_d = pending_sel_q;
        cnt_d        = '0;
        state_d      = StPrst;
      end
      StPrst: begin
        if (cnt_q == CntLast) state_d = StActive;
        else                  cnt_d   = cnt_q + CntW'(1);
      end
      default: state_d = StPrst;
    endcase
  end

  always_comb begin
    sel_oh_q = '0;
    sel_oh_d = '0;
    for (int i = 0; i < USER_PROJECTS; i++) begin
      sel_oh_q[i] = (active_sel_q == CFG_BITS'(i));
      sel_oh_d[i] = (active_sel_d == CFG_BITS'(i));
    end
  end

  // Project controls are registered from next state so they line up with state_q
  always_comb begin
    clk_en_d = (state_d == StSwitchOut) ? '0 : sel_oh_d;
    rst_n_d  = (state_d == StActive) ? sel_oh_d : '0;
  end

  always_comb begin
    io_out_d = {IO_PADS{OutSafe}};
    io_oeb_d = {IO_PADS{OebSafe}};
    la_d     = '0;
    irq_d    = '0;
    if (is_active) begin
      io_out_d[PadW-1:0] = out_sel;
      io_oeb_d[PadW-1:0] = oeb_sel;
      la_d               = 128'(la_sel);
      irq_d              = irq_sel;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q       <= StPrst;
      cnt_q         <= '0;
      active_sel_q  <= strap_ok ? strap_cfg_i : '0;
      pending_sel_q <= '0;
      cfg_ack_q     <= 1'b0;
      clk_en_q      <= '0;
      rst_n_q       <= '0;
      io_out_q      <= {IO_PADS{OutSafe}};
      io_oeb_q      <= {IO_PADS{OebSafe}};
      la_q          <= '0;
      irq_q         <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      active_sel_q  <= active_sel_d;
      pending_sel_q <= pending_sel_d;
      cfg_ack_q     <= cfg_req;
      clk_en_q      <= clk_en_d;
      rst_n_q       <= rst_n_d;
      io_out_q      <= io_out_d;
      io_oeb_q      <= io_oeb_d;
      la_q          <= la_d;
      irq_q         <= irq_d;
    end
  end

  always_comb begin
    cfg_rd                 = '0;
    cfg_rd[BusyBit]        = ~is_active;
    cfg_rd[CFG_BITS-1:0]   = active_sel_q;
  end

  assign fwd            = is_active & ~cfg_hit;
  assign fwd_ack        = fwd & wbs_stb_i & wbs_cyc_i & |(proj_wbs_ack_i & sel_oh_q);
  assign proj_wbs_stb_o = {USER_PROJECTS{fwd & wbs_stb_i}} & sel_oh_q;
  assign proj_wbs_cyc_o = {USER_PROJECTS{fwd & wbs_cyc_i}} & sel_oh_q;
  assign wbs_ack_o      = cfg_ack_q | fwd_ack;
  assign wbs_dat_o      = cfg_ack_q ? cfg_rd : (fwd_ack ? dat_sel : '0);

  assign la_data_out   = la_q;
  assign io_out        = io_out_q;
  assign io_oeb        = io_oeb_q;
  assign user_irq      = irq_q;
  assign proj_clk_en_o = clk_en_q;
  assign proj_rst_n_o  = rst_n_q;
  assign active_sel_o  = active_sel_q;
  assign switch_busy_o = ~is_active;

  user_proj_mux #(.WIDTH(32), .N(USER_PROJECTS), .SEL_BITS(CFG_BITS)) u_mux_dat (
    .data_i(proj_wbs_dat_i), .sel_i(active_sel_q), .data_o(dat_sel)
  );
  user_proj_mux #(.WIDTH(LA_BITS), .N(USER_PROJECTS), .SEL_BITS(CFG_BITS)) u_mux_la (
    .data_i(proj_la_i), .sel_i(active_sel_q), .data_o(la_sel)
  );
  user_proj_mux #(.WIDTH(PadW), .N(USER_PROJECTS), .SEL_BITS(CFG_BITS)) u_mux_out (
    .data_i(proj_io_out_i), .sel_i(active_sel_q), .data_o(out_sel)
  );
  user_proj_mux #(.WIDTH(PadW), .N(USER_PROJECTS), .SEL_BITS(CFG_BITS)) u_mux_oeb (
    .data_i(proj_io_oeb_i), .sel_i(active_sel_q), .data_o(oeb_sel)
  );
  user_proj_mux #(.WIDTH(3), .N(USER_PROJECTS), .SEL_BITS(CFG_BITS)) u_mux_irq (
    .data_i(proj_irq_i), .sel_i(active_sel_q), .data_o(irq_sel)
  );

endmodule

// File: tb/tb_user_project_switcher.sv
// Randomized bench for user_project_switcher against a cycle-level behavioural model.
module tb_user_project_switcher;

  // Three projects so the 2-bit strap and config value can encode an out-of-range select
  localparam int unsigned NP  = 3;
  localparam int unsigned CB  = 2;
  localparam int unsigned IOP = 38;
  localparam int unsigned LAB = 32;
  localparam int unsigned RC  = 4;
  localparam int unsigned PW  = IOP - CB;
  localparam logic [31:0] CfgAdr = 32'h300F_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n, stb, cyc, we, ack, busy;
  logic [3:0]        sel;
  logic [31:0]       adr, wdat, rdat;
  logic [CB-1:0]     strap, asel;
  logic [NP-1:0]     p_stb, p_cyc, p_ack, clk_en, prst_n;
  logic [32*NP-1:0]  p_dat;
  logic [LAB*NP-1:0] p_la;
  logic [127:0]      la;
  logic [PW*NP-1:0]  p_out, p_oeb;
  logic [IOP-1:0]    io_out, io_oeb;
  logic [3*NP-1:0]   p_irq;
  logic [2:0]        irq;

  user_project_switcher #(
    .USER_PROJECTS(NP), .CFG_BITS(CB), .CFG_ADDRESS(CfgAdr),
    .IO_PADS(IOP), .LA_BITS(LAB), .RST_CYCLES(RC)
  ) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .wbs_stb_i(stb), .wbs_cyc_i(cyc), .wbs_we_i(we), .wbs_sel_i(sel),
    .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
    .strap_cfg_i(strap),
    .proj_wbs_stb_o(p_stb), .proj_wbs_cyc_o(p_cyc), .proj_wbs_ack_i(p_ack),
    .proj_wbs_dat_i(p_dat), .proj_la_i(p_la), .la_data_out(la),
    .proj_io_out_i(p_out), .proj_io_oeb_i(p_oeb), .io_out(io_out), .io_oeb(io_oeb),
    .proj_irq_i(p_irq), .user_irq(irq),
    .proj_clk_en_o(clk_en), .proj_rst_n_o(prst_n),
    .active_sel_o(asel), .switch_busy_o(busy)
  );

  // Model: m_rem counts busy cycles left; RC+1 marks the handover cycle
  int             m_rem, m_sel, m_pend;
  bit             m_ack, m_rst_edge;
  logic [IOP-1:0] m_out, m_oeb;
  logic [127:0]   m_la;
  logic [2:0]     m_irq;
  int             n_cmp = 0;
  int             n_err = 0;

  task automatic check_val(string tag, logic [127:0] got, logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NP-1:0] onehot(int s);
    logic [NP-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  task automatic check_all();
    bit            act, fwd, fack;
    logic [NP-1:0] oh;
    logic [31:0]   edat;
    act  = (m_rem == 0);
    oh   = onehot(m_sel);
    fwd  = act && (adr != CfgAdr);
    fack = fwd && stb && cyc && p_ack[m_sel];
    edat = '0;
    if (m_ack) begin
      edat     = 32'(m_sel);
      edat[31] = !act;
    end else if (fack) begin
      edat = p_dat[m_sel*32 +: 32];
    end
    check_val("busy", 128'(busy), 128'(!act));
    check_val("active_sel", 128'(asel), 128'(m_sel));
    check_val("clk_en", 128'(clk_en), 128'((m_rst_edge || m_rem == RC + 1) ? '0 : oh));
    check_val("rst_n", 128'(prst_n), 128'(act ? oh : '0));
    check_val("proj_stb", 128'(p_stb), 128'((fwd && stb) ? oh : '0));
    check_val("proj_cyc", 128'(p_cyc), 128'((fwd && cyc) ? oh : '0));
    check_val("wbs_ack", 128'(ack), 128'(m_ack || fack));
    check_val("wbs_dat", 128'(rdat), 128'(edat));
    check_val("io_out", 128'(io_out), 128'(m_out));
    check_val("io_oeb", 128'(io_oeb), 128'(m_oeb));
    check_val("la", la, m_la);
    check_val("irq", 128'(irq), 128'(m_irq));
  endtask

  task automatic tick();
    bit act, req, wr_ok;
    act   = (m_rem == 0);
    req   = stb && cyc && (adr == CfgAdr) && !m_ack;
    wr_ok = req && we && sel[0] && act && (wdat < NP) && (int'(wdat) != m_sel);
    m_out = '0;
    m_oeb = '1;
    m_la  = '0;
    m_irq = '0;
    if (rst_n && act) begin
      m_out[PW-1:0] = p_out[m_sel*PW +: PW];
      m_oeb[PW-1:0] = p_oeb[m_sel*PW +: PW];
      m_la          = 128'(p_la[m_sel*LAB +: LAB]);
      m_irq         = p_irq[m_sel*3 +: 3];
    end
    if (!rst_n) begin
      m_rem      = RC;
      m_sel      = (strap < NP) ? int'(strap) : 0;
      m_ack      = 1'b0;
      m_rst_edge = 1'b1;
    end else begin
      m_rst_edge = 1'b0;
      m_ack      = req;
      if (act) begin
        if (wr_ok) begin
          m_rem  = RC + 1;
          m_pend = int'(wdat);
        end
      end else begin
        if (m_rem == RC + 1) m_sel = m_pend;
        m_rem--;
      end
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(bit s, bit c, bit w, logic [31:0] a, logic [31:0] d);
    stb  = s;
    cyc  = c;
    we   = w;
    sel  = 4'hF;
    adr  = a;
    wdat = d;
  endtask

  task automatic rand_proj();
    for (int i = 0; i < NP; i++) begin
      p_dat[i*32 +: 32]  = $urandom;
      p_la[i*LAB +: LAB] = $urandom;
      p_out[i*PW +: PW]  = PW'({$urandom, $urandom});
      p_oeb[i*PW +: PW]  = PW'({$urandom, $urandom});
      p_irq[i*3 +: 3]    = 3'($urandom);
    end
    p_ack = NP'($urandom);
  endtask

  initial begin
    rst_n = 1'b0;
    strap = 2'd2;
    drive(0, 0, 0, 32'h0, 32'h0);
    rand_proj();
    m_rem = RC; m_sel = 0; m_pend = 0; m_ack = 1'b0; m_rst_edge = 1'b1;
    m_out = '0; m_oeb = '1; m_la = '0; m_irq = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    // Switch to project 1, then hold a project read across the stall
    drive(1, 1, 1, CfgAdr, 32'd1);
    tick();
    drive(1, 1, 0, 32'h3000_0004, 32'h0);
    p_ack = '1;
    p_dat[32 +: 32] = 32'hA5A5_A5A5;
    repeat (7) tick();
    drive(1, 1, 0, CfgAdr, 32'h0);
    repeat (2) tick();
    // Invalid config writes: 7 and busy-time write of 2
    drive(1, 1, 1, CfgAdr, 32'd7);
    repeat (2) tick();
    drive(1, 1, 1, CfgAdr, 32'd0);
    tick();
    drive(1, 1, 1, CfgAdr, 32'd2);
    repeat (2) tick();
    drive(0, 0, 0, 32'h0, 32'h0);
    repeat (6) tick();
    // Out-of-range strap falls back to project 0
    rst_n = 1'b0;
    strap = 2'd3;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    for (int c = 0; c < 4000; c++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      strap = CB'($urandom);
      stb   = ($urandom_range(0, 3) != 0);
      cyc   = ($urandom_range(0, 3) != 0);
      we    = 1'($urandom);
      sel   = 4'($urandom);
      adr   = ($urandom_range(0, 2) == 0) ? CfgAdr : (32'h3000_0000 | 32'($urandom_range(0, 63) << 2));
      wdat  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 7));
      rand_proj();
      tick();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
